// File: rtl/dyt_writeback_stage_pkg.sv
// Shared types for the writeback stage: widths, write-back source select,
// load funct3 encodings and the MEM->WB register bundle.
package dyt_writeback_stage_pkg;

   localparam int XLEN      = 32;
   localparam int NREG_BITS = 5;
   localparam int CNT_W     = 64;

   typedef logic [XLEN-1:0]      word_t;
   typedef logic [NREG_BITS-1:0] reg_idx_t;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_RSVD = 2'd3
   } wb_sel_t;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   typedef struct packed {
      logic       reg_write;
      reg_idx_t   rd;
      wb_sel_t    wb_sel;
      logic [2:0] funct3;
      word_t      alu_result;
      word_t      load_data;
      word_t      pc4;
   } wb_bundle_t;

endpackage

// File: rtl/dyt_writeback_stage_load_align.sv
// Combinational load extraction: picks the byte/half out of an aligned word,
// extends it, and flags misaligned or unsupported load encodings.
module dyt_load_align
   import dyt_writeback_stage_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            misalign
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word[7:0];
      case (offset)
         2'd0:    byte_v = word[7:0];
         2'd1:    byte_v = word[15:8];
         2'd2:    byte_v = word[23:16];
         default: byte_v = word[31:24];
      endcase
      half_v = offset[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      data     = '0;
      misalign = 1'b0;
      case (funct3)
         LOAD_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
         LOAD_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
         LOAD_LH: begin
            data     = {{(XLEN-16){half_v[15]}}, half_v};
            misalign = offset[0];
         end
         LOAD_LHU: begin
            data     = {{(XLEN-16){1'b0}}, half_v};
            misalign = offset[0];
         end
         LOAD_LW: begin
            data     = word;
            misalign = (offset != 2'd0);
         end
         // Reserved load encodings are reported through the misalign trap.
         default:  misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/dyt_writeback_stage.sv
// Writeback stage: one-entry MEM/WB register, result select, register file
// write port, WB->EX bypass, misaligned-load trap and retire counter.
module dyt_writeback_stage
   import dyt_writeback_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_reg_write,
   input  logic [4:0]  mem_rd,
   input  logic [1:0]  mem_wb_sel,
   input  logic [2:0]  mem_funct3,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_load_data,
   input  logic [31:0] mem_pc4,
   input  logic        halt,
   output logic        rf_wen,
   output logic [4:0]  rf_w_sel,
   output logic [31:0] rf_w_data,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rd,
   output logic [31:0] fwd_data,
   output logic        trap_misalign,
   output logic [31:0] trap_addr,
   output logic [63:0] instret
);

   wb_bundle_t             wb_q, wb_d;
   logic                   wb_valid_q, wb_valid_d;
   logic [CNT_W-1:0]       instret_q, instret_d;

   logic                   retire;
   logic                   accept;
   logic                   misalign;
   logic                   count_en;
   logic [XLEN-1:0]        load_data;
   logic                   load_misalign;
   logic [XLEN-1:0]        wb_data;

   // Valid/ready: a transfer happens when mem_valid & mem_ready; the held entry
   // leaves on retire, so a new one can load in the same cycle without a bubble.
   assign retire    = wb_valid_q & ~halt;
   assign mem_ready = ~wb_valid_q | retire;
   assign accept    = mem_valid & mem_ready;

   dyt_load_align u_load_align (
      .word     (wb_q.load_data),
      .offset   (wb_q.alu_result[1:0]),
      .funct3   (wb_q.funct3),
      .data     (load_data),
      .misalign (load_misalign)
   );

   always_comb begin
      misalign = (wb_q.wb_sel == WB_LOAD) & load_misalign;
      case (wb_q.wb_sel)
         WB_LOAD: wb_data = load_data;
         WB_PC4:  wb_data = wb_q.pc4;
         default: wb_data = wb_q.alu_result;
      endcase
   end

   always_comb begin
      wb_d       = wb_q;
      wb_valid_d = wb_valid_q;
      if (accept) begin
         wb_d.reg_write  = mem_reg_write;
         wb_d.rd         = mem_rd;
         wb_d.wb_sel     = wb_sel_t'(mem_wb_sel);
         wb_d.funct3     = mem_funct3;
         wb_d.alu_result = mem_alu_result;
         wb_d.load_data  = mem_load_data;
         wb_d.pc4        = mem_pc4;
         wb_valid_d      = 1'b1;
      end else if (retire) begin
         wb_valid_d = 1'b0;
      end
   end

   // Trapping loads retire without counting; x0 and no-write instructions count.
   assign count_en  = retire & ~misalign;
   assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, count_en};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_q       <= '0;
         wb_valid_q <= 1'b0;
         instret_q  <= '0;
      end else begin
         wb_q       <= wb_d;
         wb_valid_q <= wb_valid_d;
         instret_q  <= instret_d;
      end
   end

   always_comb begin
      rf_wen        = retire & wb_q.reg_write & (wb_q.rd != '0) & ~misalign;
      rf_w_sel      = wb_q.rd;
      rf_w_data     = wb_data;
      fwd_valid     = rf_wen;
      fwd_rd        = wb_q.rd;
      fwd_data      = wb_data;
      trap_misalign = retire & misalign;
      trap_addr     = wb_q.alu_result;
      instret       = instret_q;
   end

endmodule
